// File: rtl/dram_reset_sequencer.sv
// dram_reset_sequencer: qualifies the clock-generator lock flag and sequences
// clk_in_locked / dram_reset for the DRAM clock infrastructure stage.
// Handshake: none. sw_reset is a plain synchronous request sampled on every
// clk_in edge, and a held level counts as one request per cycle. All outputs
// are registered and change only on clk_in edges or on reset_n assertion.
module dram_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 256
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       clk_locked_raw,
  input  logic       sw_reset,
  output logic       clk_in_locked,
  output logic       dram_reset,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic [1:0] fsm_state
);

  localparam int MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          loss_evt;
  logic          s1, s2;
  logic          lock_sync;

  assign lock_sync = s2;
  assign fsm_state = state;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= clk_locked_raw;
      s2 <= s1;
    end
  end

  // Next-state, counter and lock-loss decode; lock loss beats sw_reset
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_evt  = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_sync) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          loss_evt  = 1'b1;
        end else if (sw_reset) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          loss_evt  = 1'b1;
        end else if (sw_reset) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and interval counter registers
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs registered from the next state so they never glitch
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_in_locked <= 1'b0;
      dram_reset    <= 1'b1;
      ready         <= 1'b0;
    end else begin
      clk_in_locked <= (state_nxt == HOLD) || (state_nxt == RUN);
      dram_reset    <= (state_nxt != RUN);
      ready         <= (state_nxt == RUN);
    end
  end

  // Saturating lock-loss counter, cleared only by reset_n
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= 8'd0;
    end else if (loss_evt && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// Bench for dram_reset_sequencer with N=4, M=3. Expected output vectors
// {clk_in_locked, dram_reset, ready, lock_loss_count} are pushed per edge
// from the scenario timelines, then popped and compared 1ns after each edge.
module tb_dram_reset_sequencer;
  localparam int N = 4;
  localparam int M = 3;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b1;
  logic       clk_locked_raw = 1'b0;
  logic       sw_reset = 1'b0;
  logic       clk_in_locked;
  logic       dram_reset;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [1:0] fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_v, got_v;

  dram_reset_sequencer #(
    .LOCK_STABLE_CYCLES(N),
    .RESET_HOLD_CYCLES (M)
  ) dut (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .clk_locked_raw (clk_locked_raw),
    .sw_reset       (sw_reset),
    .clk_in_locked  (clk_in_locked),
    .dram_reset     (dram_reset),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .fsm_state      (fsm_state)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  function automatic logic [10:0] pack(input logic l, input logic r, input logic y, input int c);
    pack = {l, r, y, c[7:0]};
  endfunction

  function automatic int sat(input int c);
    sat = (c > 255) ? 255 : c;
  endfunction

  task automatic next_edge;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 0));
    exp_v = exp_q.pop_front();
    got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL reset_async: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
    end
    clk_locked_raw = 1'b1;
    for (int e = 0; e < 3; e++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 0));
    for (int e = 0; e < 3; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_held edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
    end
    clk_locked_raw = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_power_up;
    for (int e = 0; e < 2; e++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 0));
    for (int e = 0; e < 2; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL power_up_idle edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
    end
    // sw_reset held through WAIT_LOCK/STABLE must have no effect
    for (int e = 0; e < 12; e++) exp_q.push_back(pack(e >= N + 2, e < N + M + 2, e >= N + M + 2, 0));
    clk_locked_raw = 1'b1;
    sw_reset = 1'b1;
    for (int e = 0; e < 12; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL power_up edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
      if (e == 5) sw_reset = 1'b0;
    end
  endtask

  task automatic test_stable_drop;
    reset_n = 1'b0;
    clk_locked_raw = 1'b0;
    next_edge();
    reset_n = 1'b1;
    // raw low at E3,E4: loss seen at E5 (counter=2), requalify from E7
    for (int e = 0; e < 17; e++) exp_q.push_back(pack(e >= 11, e < 14, e >= 14, 0));
    clk_locked_raw = 1'b1;
    for (int e = 0; e < 17; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL stable_drop edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
      clk_locked_raw = !((e + 1 == 3) || (e + 1 == 4));
    end
  endtask

  task automatic test_run_loss;
    // raw low at E0..E2: loss at E2, lock seen again at E5
    for (int e = 0; e < 14; e++)
      exp_q.push_back(pack((e < 2) || (e >= 9), !((e < 2) || (e >= 12)), (e < 2) || (e >= 12), (e < 2) ? 0 : 1));
    clk_locked_raw = 1'b0;
    for (int e = 0; e < 14; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL run_loss edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
      clk_locked_raw = (e + 1 > 2);
    end
  endtask

  task automatic test_sw_reset;
    for (int e = 0; e < 5; e++) exp_q.push_back(pack(1'b1, e < M, e >= M, 1));
    sw_reset = 1'b1;
    for (int e = 0; e < 5; e++) begin
      next_edge();
      sw_reset = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sw_single edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
    end
    for (int e = 0; e < 6; e++) exp_q.push_back(pack(1'b1, e < M + 1, e >= M + 1, 1));
    sw_reset = 1'b1;
    for (int e = 0; e < 6; e++) begin
      next_edge();
      if (e == 1) sw_reset = 1'b0;
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sw_double edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_sw_and_loss;
    for (int e = 0; e < 4; e++) exp_q.push_back((e < 2) ? pack(1'b1, 1'b0, 1'b1, 1) : pack(1'b0, 1'b1, 1'b0, 2));
    clk_locked_raw = 1'b0;
    for (int e = 0; e < 4; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sw_and_loss edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
      sw_reset = (e == 1);
    end
    sw_reset = 1'b0;
  endtask

  task automatic test_saturation;
    // Each 8-edge round reaches HOLD at E6 and drops lock, loss lands on E8
    for (int i = 0; i < 260; i++) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, sat(2 + i)));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 255));
    for (int i = 0; i < 260; i++) begin
      for (int e = 0; e < 8; e++) begin
        clk_locked_raw = (e < 6);
        next_edge();
        if (e == 7) begin
          exp_v = exp_q.pop_front();
          got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
          vectors++;
          if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL saturation round %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", i, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
          end
        end
      end
    end
    clk_locked_raw = 1'b0;
    next_edge();
    exp_v = exp_q.pop_front();
    got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL saturation_final: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
    end
    next_edge();
  endtask

  task automatic test_reset_in_hold;
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 255));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 0));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 0));
    clk_locked_raw = 1'b1;
    for (int e = 0; e < 8; e++) next_edge();
    exp_v = exp_q.pop_front();
    got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL hold_before_reset: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
    end
    reset_n = 1'b0;
    #1;
    exp_v = exp_q.pop_front();
    got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL hold_reset_async: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
    end
    next_edge();
    exp_v = exp_q.pop_front();
    got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL hold_reset_held: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
    end
    reset_n = 1'b1;
    for (int e = 0; e < 11; e++) exp_q.push_back(pack(e >= N + 2, e < N + M + 2, e >= N + M + 2, 0));
    for (int e = 0; e < 11; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      got_v = {clk_in_locked, dram_reset, ready, lock_loss_count};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL requalify edge %0d: got l/r/y=%b cnt=%0d want l/r/y=%b cnt=%0d", e, got_v[10:8], got_v[7:0], exp_v[10:8], exp_v[7:0]);
      end
    end
  endtask

  // Scenario sequence and final report
  initial begin
    test_reset();
    test_power_up();
    test_stable_drop();
    test_run_loss();
    test_sw_reset();
    test_sw_and_loss();
    test_saturation();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
